// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Boot/test-path program loader. Accepts instruction field bundles over a
//   valid/ready handshake, packs each into a 32-bit MIPS word, checks it
//   against the supported opcode/funct set and writes it to instruction
//   memory at consecutive word addresses.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, sampled in IDLE/DONE/ERROR only
//   base_addr, count    job byte address (low two bits forced 0), bundle count
//   in_valid/in_ready   field bundle handshake
//   in_fmt .. in_target instruction fields (fmt 0=R, 1=I, 2=J, 3=illegal)
//   imem_we/imem_ready  write handshake to instruction memory
//   imem_addr/wdata     write address and encoded word
//   busy, done, error   job status (done is a one-cycle pulse, error sticky)
//   err_index           0-based index of the first rejected bundle
//   dbg_state           current FSM state (0 IDLE,1 LOAD,2 DRAIN,3 DONE,4 ERROR)
//
// Handshake rule (both interfaces): a transfer happens in exactly the cycle
// where valid and ready are both high at the rising clock edge. A producer
// holds its payload stable while valid is high and ready is low.
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_index,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;    // address the next accepted bundle will use

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              wr_done;
  logic [CNT_W-1:0]  idx_next;

  function automatic logic r_funct_ok(input logic [5:0] f);
    case (f)
      6'h00, 6'h02, 6'h08, 6'h10, 6'h12, 6'h19,
      6'h1B, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: r_funct_ok = 1'b1;
      default:                                  r_funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic i_op_ok(input logic [5:0] op);
    case (op)
      6'h23, 6'h2B, 6'h04, 6'h08: i_op_ok = 1'b1;
      default:                    i_op_ok = 1'b0;
    endcase
  endfunction

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (in_fmt)
      2'd0: begin
        enc_word  = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
        enc_legal = (in_opcode == 6'h00) && r_funct_ok(in_funct);
      end
      2'd1: begin
        enc_word  = {in_opcode, in_rs, in_rt, in_imm};
        enc_legal = i_op_ok(in_opcode);
      end
      2'd2: begin
        enc_word  = {in_opcode, in_target};
        enc_legal = (in_opcode == 6'h02) || (in_opcode == 6'h03);
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // The output register may reload in the same cycle its write is accepted,
  // which gives one bundle per cycle while imem_ready stays high.
  assign in_ready  = (state == S_LOAD) && (idx < count_q) && (!imem_we || imem_ready);
  assign accept    = in_valid && in_ready;
  assign wr_done   = imem_we && imem_ready;
  assign idx_next  = idx + CNT_W'(1);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_index  <= '0;
    end else begin
      done <= 1'b0;
      // A completed write retires here; a reload below overrides it.
      if (wr_done) imem_we <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            error     <= 1'b0;
            err_index <= '0;
            idx       <= '0;
            count_q   <= count;
            addr_q    <= {base_addr[ADDR_W-1:2], 2'b00};
            if (count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            if (enc_legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr_q;
              imem_wdata <= enc_word;
              addr_q     <= addr_q + ADDR_W'(4);
              idx        <= idx_next;
              if (idx_next == count_q) state <= S_DRAIN;
            end else begin
              // Rejected bundle is consumed but never written; an earlier
              // pending write is left to complete on its own.
              error     <= 1'b1;
              err_index <= idx;
              busy      <= 1'b0;
              state     <= S_ERROR;
            end
          end
        end

        S_DRAIN: begin
          if (wr_done) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, error;
  logic [15:0] err_index;
  logic [2:0]  dbg_state;

  instr_encoder_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  int          wr_cyc[$];
  int          wr_count = 0;
  int          done_cnt = 0;
  int          cyc      = 0;
  bit          ready_toggle = 1'b0;
  bit          ready_level  = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // imem_ready driver: level or alternating each cycle, updated on negedge
  initial begin
    imem_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_toggle) imem_ready = ~imem_ready;
      else              imem_ready = ready_level;
    end
  end

  // Write monitor: sampled 2 time units after the falling edge
  initial begin
    bit          prev_stall;
    logic [31:0] prev_addr, prev_data;
    logic [63:0] e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_we",   imem_we,    1);
          check("stall_addr", imem_addr,  prev_addr);
          check("stall_data", imem_wdata, prev_data);
        end
        if (imem_we && !imem_ready) check("stall_in_ready", in_ready, 0);
        if (done) done_cnt++;
        if (imem_we && imem_ready) begin
          wr_count++;
          wr_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("wr_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("wr", {imem_addr, imem_wdata}, e);
          end
        end
        prev_stall = imem_we && !imem_ready;
        prev_addr  = imem_addr;
        prev_data  = imem_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    start     = 1'b1;
    base_addr = b;
    count     = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one bundle from a negedge until accepted or max_cyc expires.
  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt,
                      input int max_cyc, output bit acc);
    in_fmt = f; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < max_cyc && !acc; c++) begin
      #1;
      if (in_ready) acc = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      #1;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_err"}, error, 0);
    @(negedge clk);
    #1;
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, 3);
    @(negedge clk);
  endtask

  // The four-instruction program used by the back-to-back and stall jobs
  task automatic send_prog4(input int max_cyc, input string tag);
    bit acc;
    send(2'd0, 6'h00, 5'd8,  5'd9, 5'd10, 5'd0, 6'h20, 16'h0,    26'h0,  max_cyc, acc);
    check({tag, "_acc0"}, acc, 1);
    send(2'd1, 6'h23, 5'd29, 5'd8, 5'd0,  5'd0, 6'h00, 16'h0004, 26'h0,  max_cyc, acc);
    check({tag, "_acc1"}, acc, 1);
    send(2'd2, 6'h02, 5'd0,  5'd0, 5'd0,  5'd0, 6'h00, 16'h0,    26'h10, max_cyc, acc);
    check({tag, "_acc2"}, acc, 1);
    send(2'd2, 6'h03, 5'd0,  5'd0, 5'd0,  5'd0, 6'h00, 16'h0,    26'h10, max_cyc, acc);
    check({tag, "_acc3"}, acc, 1);
  endtask

  task automatic push_prog4();
    exp_q.push_back({32'h0000_0040, 32'h0109_5020});
    exp_q.push_back({32'h0000_0044, 32'h8FA8_0004});
    exp_q.push_back({32'h0000_0048, 32'h0800_0010});
    exp_q.push_back({32'h0000_004C, 32'h0C00_0010});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit acc;
    int snap;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", dbg_state, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_err_index", err_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single ADDI, latency of one cycle from accept to write
    exp_q.push_back({32'h0000_0040, 32'h2008_0005});
    do_start(32'h0000_0040, 16'd1);
    #1;
    check("t1_busy", busy, 1);
    @(negedge clk);
    send(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 5, acc);
    check("t1_acc", acc, 1);
    #1;
    check("t1_lat_we", imem_we, 1);
    check("t1_lat_addr", imem_addr, 32'h0000_0040);
    check("t1_lat_data", imem_wdata, 32'h2008_0005);
    wait_done("t1");
    check("t1_sb", exp_q.size(), 0);

    // 2: four bundles back-to-back with imem_ready held high
    push_prog4();
    wr_cyc.delete();
    do_start(32'h0000_0040, 16'd4);
    send_prog4(1, "t2");
    wait_done("t2");
    check("t2_sb", exp_q.size(), 0);
    check("t2_nwr", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) check("t2_consecutive", wr_cyc[3] - wr_cyc[0], 3);

    // 3: same job, imem_ready alternating every cycle
    push_prog4();
    snap = wr_count;
    ready_toggle = 1'b1;
    do_start(32'h0000_0040, 16'd4);
    send_prog4(10, "t3");
    wait_done("t3");
    ready_toggle = 1'b0;
    ready_level  = 1'b1;
    check("t3_sb", exp_q.size(), 0);
    check("t3_nwr", wr_count - snap, 4);

    // 4: illegal second bundle (I-type opcode 0x0D)
    exp_q.push_back({32'h0000_0040, 32'h2008_0005});
    snap = done_cnt;
    do_start(32'h0000_0040, 16'd3);
    send(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 5, acc);
    check("t4_acc0", acc, 1);
    send(2'd1, 6'h0D, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h00FF, 26'h0, 5, acc);
    check("t4_acc1", acc, 1);
    #1;
    check("t4_error", error, 1);
    check("t4_err_index", err_index, 1);
    check("t4_state", dbg_state, 4);
    check("t4_in_ready", in_ready, 0);
    check("t4_busy", busy, 0);
    @(negedge clk);
    send(2'd0, 6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0, 5, acc);
    check("t4_acc2_blocked", acc, 0);
    check("t4_no_done", done_cnt - snap, 0);
    check("t4_sb", exp_q.size(), 0);
    check("t4_error_sticky", error, 1);
    do_start(32'h0000_0080, 16'd0);
    #1;
    check("t4_restart_clears", error, 0);
    check("t4_restart_done", done, 1);
    @(negedge clk);

    // 5: address wrap at the top of the address space
    exp_q.push_back({32'hFFFF_FFFC, 32'h0800_0010});
    exp_q.push_back({32'h0000_0000, 32'h0C00_0010});
    do_start(32'hFFFF_FFFF, 16'd2);  // low two bits must be dropped
    send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h10, 5, acc);
    check("t5_acc0", acc, 1);
    send(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h10, 5, acc);
    check("t5_acc1", acc, 1);
    wait_done("t5");
    check("t5_sb", exp_q.size(), 0);

    // count == 0: done on the next cycle, no write
    snap = wr_count;
    do_start(32'h0000_0200, 16'd0);
    #1;
    check("t5z_done", done, 1);
    check("t5z_we", imem_we, 0);
    @(negedge clk);
    #1;
    check("t5z_done_1cyc", done, 0);
    check("t5z_state", dbg_state, 3);
    check("t5z_nwr", wr_count - snap, 0);
    @(negedge clk);

    // 6: reset while a write is stalled
    ready_level = 1'b0;
    @(negedge clk);
    do_start(32'h0000_0100, 16'd1);
    send(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 5, acc);
    check("t6_acc", acc, 1);
    #1;
    check("t6_we_pending", imem_we, 1);
    check("t6_ready_low", imem_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_we_drop", imem_we, 0);
    check("t6_busy_drop", busy, 0);
    check("t6_addr_rst", imem_addr, 0);
    check("t6_wdata_rst", imem_wdata, 0);
    check("t6_state_rst", dbg_state, 0);
    ready_level = 1'b1;
    snap = wr_count;
    @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t6_state_idle", dbg_state, 0);
    check("t6_no_stale_we", imem_we, 0);
    check("t6_no_stale_wr", wr_count - snap, 0);
    check("t6_done_idle", done, 0);

    check("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
